// File: rtl/hs_pipe_dnsize.sv
// Wide-to-narrow valid/ready downsizer: holds one IN_WIDTH word and replays it as OUT_WIDTH beats.
// Optional build macro HS_PIPE_DNSIZE_MSB_FIRST_EN presents the most-significant lane first.
module hs_pipe_dnsize #(
    parameter  int IN_WIDTH  = 256,
    parameter  int OUT_WIDTH = 32,
    localparam int RATIO     = IN_WIDTH / OUT_WIDTH,
    localparam int LW        = $clog2(RATIO)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 data_in_vld,
    input  logic [IN_WIDTH-1:0]  data_in,
    input  logic [LW-1:0]        data_in_nl,
    output logic                 data_in_rdy,
    output logic                 data_out_vld,
    output logic [OUT_WIDTH-1:0] data_out,
    output logic                 data_out_last,
    input  logic                 data_out_rdy
);

    // state | meaning
    // EMPTY | no word held; ready for a new word, no beat presented
    // SEND  | word held; presenting lane[lane_q], last when lane_q == nl_q

    typedef enum logic {
        EMPTY = 1'b0,
        SEND  = 1'b1
    } state_t;

    localparam logic [LW-1:0] NL_MAX = LW'(RATIO - 1);

    generate
        if (RATIO < 2 || (IN_WIDTH % OUT_WIDTH) != 0) begin : g_bad_params
            $error("hs_pipe_dnsize: IN_WIDTH must be a multiple (>= 2) of OUT_WIDTH");
        end
    endgenerate

    state_t                 state_q;
    state_t                 state_d;
    logic [IN_WIDTH-1:0]    hold_q;
    logic [LW-1:0]          nl_q;
    logic [LW-1:0]          lane_q;
    logic [LW-1:0]          nl_in;
    logic [OUT_WIDTH-1:0]   lane_sel;
    logic                   full;
    logic                   at_last;
    logic                   load;
    logic                   adv;

    // Lane counts beyond the last real lane only exist when RATIO is not a power of two.
    generate
        if ((1 << LW) == RATIO) begin : g_nl_pow2
            assign nl_in = data_in_nl;
        end else begin : g_nl_clamp
            assign nl_in = (data_in_nl > NL_MAX) ? NL_MAX : data_in_nl;
        end
    endgenerate

    assign full    = (state_q == SEND);
    assign at_last = (lane_q == nl_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // data_in_rdy follows data_out_rdy combinationally on the final beat so
    // a new word can load in the same cycle the old one retires.
    always_comb begin
        state_d      = state_q;
        load         = 1'b0;
        adv          = 1'b0;
        data_in_rdy  = 1'b0;
        data_out_vld = 1'b0;
        case (state_q)
            EMPTY: begin
                data_in_rdy = 1'b1;
                if (data_in_vld) begin
                    load    = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                data_out_vld = 1'b1;
                if (data_out_rdy) begin
                    if (at_last) begin
                        data_in_rdy = 1'b1;
                        if (data_in_vld) begin
                            load = 1'b1;
                        end else begin
                            state_d = EMPTY;
                        end
                    end else begin
                        adv = 1'b1;
                    end
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q <= '0;
            nl_q   <= '0;
            lane_q <= '0;
        end else if (load) begin
            hold_q <= data_in;
            nl_q   <= nl_in;
            lane_q <= '0;
        end else if (adv) begin
            lane_q <= lane_q + 1'b1;
        end
    end

    always_comb begin
        lane_sel = '0;
        for (int k = 0; k < RATIO; k++) begin
            if (lane_q == LW'(k)) begin
`ifdef HS_PIPE_DNSIZE_MSB_FIRST_EN
                lane_sel = hold_q[(RATIO-1-k)*OUT_WIDTH +: OUT_WIDTH];
`else
                lane_sel = hold_q[k*OUT_WIDTH +: OUT_WIDTH];
`endif
            end
        end
    end

    assign data_out      = full ? lane_sel : '0;
    assign data_out_last = full & at_last;

endmodule

// File: tb/tb_hs_pipe_dnsize.sv
// Self-checking bench for hs_pipe_dnsize: vector table plus scoreboard of expected beats.
module tb_hs_pipe_dnsize;

    localparam int IW = 256;
    localparam int OW = 32;
    localparam int R  = IW / OW;
    localparam int LW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          data_in_vld = 1'b0;
    logic [IW-1:0] data_in = '0;
    logic [LW-1:0] data_in_nl = '0;
    logic          data_in_rdy;
    logic          data_out_vld;
    logic [OW-1:0] data_out;
    logic          data_out_last;
    logic          data_out_rdy = 1'b1;

    hs_pipe_dnsize #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
        .clk          (clk),
        .rst          (rst),
        .data_in_vld  (data_in_vld),
        .data_in      (data_in),
        .data_in_nl   (data_in_nl),
        .data_in_rdy  (data_in_rdy),
        .data_out_vld (data_out_vld),
        .data_out     (data_out),
        .data_out_last(data_out_last),
        .data_out_rdy (data_out_rdy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [OW-1:0] data;
        logic          last;
    } beat_t;

    typedef struct {
        logic [IW-1:0] data;
        logic [LW-1:0] nl;
        logic [7:0]    rdy_pat;
        bit            b2b;
        logic [OW-1:0] exp_first;
        logic [OW-1:0] exp_final;
    } vec_t;

    beat_t         sbq[$];
    logic [OW-1:0] cap_first[$];
    logic [OW-1:0] cap_final[$];
    vec_t          vecs[$];
    int            n_checks = 0;
    int            n_pass   = 0;
    int            pop_cnt  = 0;
    bit            in_word  = 0;
    logic [7:0]    rdy_pat  = 8'hFF;
    int            ridx     = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [OW-1:0] lane_of(input logic [IW-1:0] w, input int i);
`ifdef HS_PIPE_DNSIZE_MSB_FIRST_EN
        return w[(R-1-i)*OW +: OW];
`else
        return w[i*OW +: OW];
`endif
    endfunction

    function automatic logic [IW-1:0] mk_word(input logic [OW-1:0] base);
        logic [IW-1:0] w;
        for (int k = 0; k < R; k++) w[k*OW +: OW] = base + OW'(k);
        return w;
    endfunction

    function automatic logic [IW-1:0] one_lane(input logic [OW-1:0] v);
        logic [IW-1:0] w = '0;
`ifdef HS_PIPE_DNSIZE_MSB_FIRST_EN
        w[(R-1)*OW +: OW] = v;
`else
        w[OW-1:0] = v;
`endif
        return w;
    endfunction

    // ready pattern replayed one bit per cycle
    initial begin
        forever begin
            @(posedge clk);
            #1;
            data_out_rdy = rdy_pat[ridx];
            ridx = (ridx + 1) % 8;
        end
    end

    // scoreboard monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (!rst) begin
            chk("vld", 64'(data_out_vld), 64'(sbq.size() != 0));
            chk("in_rdy", 64'(data_in_rdy),
                64'((sbq.size() == 0) || (data_out_rdy && sbq.size() == 1)));
            if (data_out_vld && sbq.size() != 0) begin
                chk("data", 64'(data_out), 64'(sbq[0].data));
                chk("last", 64'(data_out_last), 64'(sbq[0].last));
                if (data_out_rdy) begin
                    void'(sbq.pop_front());
                    pop_cnt++;
                    if (!in_word) cap_first.push_back(data_out);
                    in_word = 1;
                    if (data_out_last) begin
                        cap_final.push_back(data_out);
                        in_word = 0;
                    end
                end
            end
            if (data_in_vld && data_in_rdy) begin
                for (int i = 0; i <= int'(data_in_nl); i++) begin
                    beat_t b;
                    b.data = lane_of(data_in, i);
                    b.last = (i == int'(data_in_nl));
                    sbq.push_back(b);
                end
            end
        end
    end

    task automatic send_word(input logic [IW-1:0] w, input logic [LW-1:0] nl);
        bit acc = 0;
        data_in_vld = 1'b1;
        data_in     = w;
        data_in_nl  = nl;
        for (int i = 0; i < 100 && !acc; i++) begin
            @(negedge clk);
            acc = data_in_rdy;
            @(posedge clk);
            #1;
        end
        data_in_vld = 1'b0;
        if (!acc) chk("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_drain();
        bit done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(posedge clk);
            if (sbq.size() == 0) done = 1;
        end
        #1;
        if (!done) chk("drain_timeout", 64'd0, 64'd1);
    endtask

    task automatic add_vec(input logic [IW-1:0] w, input logic [LW-1:0] nl,
                           input logic [7:0] pat, input bit b2b);
        vec_t v;
        v.data      = w;
        v.nl        = nl;
        v.rdy_pat   = pat;
        v.b2b       = b2b;
        v.exp_first = lane_of(w, 0);
        v.exp_final = lane_of(w, int'(nl));
        vecs.push_back(v);
    endtask

    initial begin
        logic [IW-1:0] w;
        int p0;
        bit hit;

        add_vec(mk_word(32'h0),          3'd7, 8'hFF,        1'b0);
        add_vec(one_lane(32'hA5A5A5A5),  3'd0, 8'hFF,        1'b1);
        add_vec(one_lane(32'h5A5A5A5A),  3'd0, 8'hFF,        1'b0);
        add_vec(mk_word(32'h100),        3'd7, 8'b1001_1001, 1'b0);
        add_vec(mk_word(32'h200),        3'd2, 8'b0110_1011, 1'b1);
        add_vec(mk_word(32'h280),        3'd4, 8'b1101_0111, 1'b0);
`ifdef HS_PIPE_DNSIZE_MSB_FIRST_EN
        w = '0;
        w[7*OW +: OW] = 32'h11111111;
        w[6*OW +: OW] = 32'h22222222;
        add_vec(w, 3'd1, 8'hFF, 1'b0);
`endif

        // reset state
        #1;
        chk("rst_vld",  64'(data_out_vld),  64'd0);
        chk("rst_data", 64'(data_out),      64'd0);
        chk("rst_last", 64'(data_out_last), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_in_rdy", 64'(data_in_rdy), 64'd1);

        foreach (vecs[i]) begin
            rdy_pat = vecs[i].rdy_pat;
            send_word(vecs[i].data, vecs[i].nl);
            if (!vecs[i].b2b) wait_drain();
        end
        wait_drain();

        chk("n_first", 64'(cap_first.size()), 64'(vecs.size()));
        chk("n_final", 64'(cap_final.size()), 64'(vecs.size()));
        foreach (vecs[i]) begin
            if (i < cap_first.size()) chk($sformatf("first_%0d", i), 64'(cap_first[i]), 64'(vecs[i].exp_first));
            if (i < cap_final.size()) chk($sformatf("final_%0d", i), 64'(cap_final[i]), 64'(vecs[i].exp_final));
        end

        // reset in the middle of a full word
        rdy_pat = 8'hFF;
        w = mk_word(32'h300);
        send_word(w, 3'd7);
        p0  = pop_cnt;
        hit = 0;
        for (int i = 0; i < 50 && !hit; i++) begin
            @(posedge clk);
            if (pop_cnt >= p0 + 4) hit = 1;
        end
        if (!hit) chk("midrst_timeout", 64'd0, 64'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_vld",  64'(data_out_vld),  64'd0);
        chk("midrst_data", 64'(data_out),      64'd0);
        chk("midrst_last", 64'(data_out_last), 64'd0);
        sbq.delete();
        in_word = 0;
        cap_first.delete();
        cap_final.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("midrst_vld_after",  64'(data_out_vld), 64'd0);
        chk("midrst_rdy_after",  64'(data_in_rdy),  64'd1);

        w = mk_word(32'h400);
        send_word(w, 3'd3);
        wait_drain();
        chk("post_rst_n", 64'(cap_first.size()), 64'd1);
        if (cap_first.size() > 0) chk("post_rst_first", 64'(cap_first[0]), 64'(lane_of(w, 0)));
        if (cap_final.size() > 0) chk("post_rst_final", 64'(cap_final[0]), 64'(lane_of(w, 3)));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
